// File: rtl/fp16_result_packer.sv
// Packs the converter's serial FP16 results into 256-bit, 16-lane write words,
// buffers completed words in a small FIFO and presents them on a valid/ready
// write port with auto-incrementing word addresses and byte strobes.
module fp16_result_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [15:0]           i_fp16_result,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic [255:0]          o_wr_data,
    output logic [31:0]           o_wr_strb,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic                  o_overflow,
    output logic                  o_tile_done,
    output logic                  o_idle
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]            lane_cnt_q,  lane_cnt_d;
    logic [255:0]          lane_data_q, lane_data_d;
    logic [31:0]           lane_strb_q, lane_strb_d;
    logic [ADDR_WIDTH-1:0] push_addr_q, push_addr_d;
    logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic                  overflow_q,  overflow_d;
    logic                  tile_done_q, tile_done_d;
    logic                  pending_q,   pending_d;

    logic [255:0]          mem_data_q [FIFO_DEPTH];
    logic [31:0]           mem_strb_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic                  mem_last_q [FIFO_DEPTH];

    // View of the state as seen after an i_start in this cycle has been applied.
    logic [3:0]            base_cnt;
    logic [255:0]          base_data;
    logic [31:0]           base_strb;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [PTR_W-1:0]      base_wr;
    logic [CNT_W-1:0]      base_count;

    logic [255:0]          word_data;
    logic [31:0]           word_strb;
    logic                  head_valid;
    logic                  pop;
    logic                  complete;
    logic                  push_en;

    assign head_valid = (count_q != '0);

    // Next-state: lane merge, word completion, FIFO push/pop/drop, address and flags.
    always_comb begin
        base_cnt   = i_start ? 4'd0        : lane_cnt_q;
        base_data  = i_start ? '0          : lane_data_q;
        base_strb  = i_start ? '0          : lane_strb_q;
        base_addr  = i_start ? i_base_addr : push_addr_q;
        base_wr    = i_start ? '0          : wr_ptr_q;
        base_count = i_start ? '0          : count_q;

        // A start flushes the FIFO, so a handshake in the same cycle is void.
        pop = !i_start && head_valid && i_wr_ready;

        word_data = base_data;
        word_strb = base_strb;
        if (i_valid) begin
            word_data[{base_cnt, 4'b0000} +: 16] = i_fp16_result;
            word_strb[{base_cnt, 1'b0} +: 2]     = 2'b11;
        end

        complete = i_valid && ((base_cnt == 4'd15) || i_last);
        push_en  = complete && !((base_count == CNT_W'(FIFO_DEPTH)) && !pop);

        lane_cnt_d  = base_cnt;
        lane_data_d = word_data;
        lane_strb_d = word_strb;
        if (complete) begin
            lane_cnt_d  = 4'd0;
            lane_data_d = '0;
            lane_strb_d = '0;
        end else if (i_valid) begin
            lane_cnt_d = base_cnt + 4'd1;
        end

        // Address advances even for dropped words so later words stay aligned.
        push_addr_d = base_addr + ADDR_WIDTH'(complete);
        wr_ptr_d    = base_wr + PTR_W'(push_en);
        rd_ptr_d    = (i_start ? '0 : rd_ptr_q) + PTR_W'(pop);
        count_d     = base_count + CNT_W'(push_en) - CNT_W'(pop);

        overflow_d  = (i_start ? 1'b0 : overflow_q) | (complete && !push_en);
        tile_done_d = pop && mem_last_q[rd_ptr_q];

        pending_d = i_start ? 1'b1 : pending_q;
        if (tile_done_d) begin
            pending_d = 1'b0;
        end
        if (i_valid) begin
            pending_d = 1'b1;
        end
    end

    // Control and lane state registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            lane_cnt_q  <= '0;
            lane_data_q <= '0;
            lane_strb_q <= '0;
            push_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            tile_done_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            lane_data_q <= lane_data_d;
            lane_strb_q <= lane_strb_d;
            push_addr_q <= push_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            tile_done_q <= tile_done_d;
            pending_q   <= pending_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the outputs.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem_data_q[base_wr] <= word_data;
            mem_strb_q[base_wr] <= word_strb;
            mem_addr_q[base_wr] <= base_addr;
            mem_last_q[base_wr] <= i_last;
        end
    end

    assign o_wr_valid  = head_valid;
    assign o_wr_data   = head_valid ? mem_data_q[rd_ptr_q] : '0;
    assign o_wr_strb   = head_valid ? mem_strb_q[rd_ptr_q] : '0;
    assign o_wr_addr   = head_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign o_overflow  = overflow_q;
    assign o_tile_done = tile_done_q;
    assign o_idle      = (lane_cnt_q == 4'd0) && !head_valid && !pending_q;

endmodule

// File: tb/tb_fp16_result_packer.sv
// Scoreboard bench for fp16_result_packer: every cycle the outputs are compared
// with a cycle-level reference model whose expected words live in a queue.
module tb_fp16_result_packer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 11;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [15:0]   i_fp16_result;
    logic          i_valid;
    logic          i_last;
    logic [255:0]  o_wr_data;
    logic [31:0]   o_wr_strb;
    logic [AW-1:0] o_wr_addr;
    logic          o_wr_valid;
    logic          i_wr_ready;
    logic          o_overflow;
    logic          o_tile_done;
    logic          o_idle;

    fp16_result_packer #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_fp16_result(i_fp16_result),
        .i_valid      (i_valid),
        .i_last       (i_last),
        .o_wr_data    (o_wr_data),
        .o_wr_strb    (o_wr_strb),
        .o_wr_addr    (o_wr_addr),
        .o_wr_valid   (o_wr_valid),
        .i_wr_ready   (i_wr_ready),
        .o_overflow   (o_overflow),
        .o_tile_done  (o_tile_done),
        .o_idle       (o_idle)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0]  d;
        logic [31:0]   s;
        logic [AW-1:0] a;
        logic          l;
    } ent_t;

    ent_t          sb_q[$];
    logic [255:0]  m_data;
    logic [31:0]   m_strb;
    int            m_cnt;
    logic [AW-1:0] m_addr;
    logic          m_ovf;
    logic          m_td;
    logic          m_pend;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_data = '0;
        m_strb = '0;
        m_cnt  = 0;
        m_addr = '0;
        m_ovf  = 1'b0;
        m_td   = 1'b0;
        m_pend = 1'b0;
    endtask

    // Compare outputs with the model, advance the model over the coming edge, then clock.
    task automatic tick();
        logic exp_v;
        logic td_n;
        ent_t e;
        exp_v = (sb_q.size() > 0);
        chk("valid", o_wr_valid, exp_v);
        chk("data",  o_wr_data,  exp_v ? sb_q[0].d : 256'd0);
        chk("strb",  o_wr_strb,  exp_v ? sb_q[0].s : 32'd0);
        chk("addr",  o_wr_addr,  exp_v ? sb_q[0].a : '0);
        chk("ovf",   o_overflow, m_ovf);
        chk("tdone", o_tile_done, m_td);
        chk("idle",  o_idle, (m_cnt == 0) && !exp_v && !m_pend);

        if (!i_reset_n) begin
            model_clear();
        end else begin
            td_n = 1'b0;
            if (i_start) begin
                sb_q.delete();
                m_data = '0;
                m_strb = '0;
                m_cnt  = 0;
                m_ovf  = 1'b0;
                m_pend = 1'b1;
                m_addr = i_base_addr;
            end else if (exp_v && i_wr_ready) begin
                td_n = sb_q[0].l;
                void'(sb_q.pop_front());
            end
            if (td_n) m_pend = 1'b0;
            if (i_valid) begin
                m_pend = 1'b1;
                m_data[m_cnt*16 +: 16] = i_fp16_result;
                m_strb[m_cnt*2 +: 2]   = 2'b11;
                if (m_cnt == 15 || i_last) begin
                    e.d = m_data;
                    e.s = m_strb;
                    e.a = m_addr;
                    e.l = i_last;
                    if (sb_q.size() < DEPTH) sb_q.push_back(e);
                    else m_ovf = 1'b1;
                    m_addr = m_addr + 1'b1;
                    m_data = '0;
                    m_strb = '0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_td = td_n;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in(input logic rdy);
        i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_wr_ready = rdy;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        idle_in(1'b1);
        i_start = 1'b1; i_base_addr = base;
        tick();
        i_start = 1'b0;
    endtask

    task automatic feed(input int n, input logic [15:0] v0, input int last_at, input logic rdy);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1; i_fp16_result = v0 + 16'(i); i_last = (i == last_at);
            i_wr_ready = rdy;
            tick();
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic drain(input int n);
        idle_in(1'b1);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        i_reset_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_fp16_result = '0;
        i_valid = 1'b0; i_last = 1'b0; i_wr_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge i_clk);
        #1;
        tick();                              // reset values checked against cleared model
        i_reset_n = 1'b1;
        tick();

        // Full tile
        do_start(11'h010);
        for (int i = 0; i < 32; i++) begin
            i_valid = 1'b1; i_fp16_result = 16'h3C00 + 16'(i); i_last = (i == 31);
            i_wr_ready = 1'b1;
            tick();
            if (i == 14) chk("ft_nv", o_wr_valid, 1'b0);
            if (i == 15) begin
                chk("ft_v0", o_wr_valid, 1'b1);
                chk("ft_a0", o_wr_addr, 11'h010);
                chk("ft_s0", o_wr_strb, 32'hFFFF_FFFF);
                chk("ft_l5", o_wr_data[95:80], 16'h3C05);
            end
            if (i == 31) begin
                chk("ft_a1", o_wr_addr, 11'h011);
                chk("ft_l16", o_wr_data[15:0], 16'h3C10);
            end
        end
        drain(3);
        chk("ft_idle", o_idle, 1'b1);

        // Partial flush
        do_start(11'h020);
        feed(5, 16'hC000, 4, 1'b1);
        chk("pf_strb", o_wr_strb, 32'h0000_03FF);
        chk("pf_hi", o_wr_data[255:80], 176'd0);
        chk("pf_l4", o_wr_data[79:64], 16'hC004);
        drain(3);

        // Backpressure without loss: ready low for the first 60 of 64 results
        do_start(11'h100);
        for (int i = 0; i < 64; i++) begin
            i_valid = 1'b1; i_fp16_result = 16'h1000 + 16'(i); i_last = (i == 63);
            i_wr_ready = (i >= 60);
            tick();
        end
        drain(6);
        chk("bp_ovf", o_overflow, 1'b0);

        // Overflow: 5 words with the sink stalled, then the next tile continues at base+5
        do_start(11'h200);
        feed(80, 16'h2000, 79, 1'b0);
        chk("of_ovf", o_overflow, 1'b1);
        chk("of_a0", o_wr_addr, 11'h200);
        drain(6);
        feed(16, 16'h2100, 15, 1'b1);
        chk("of_a5", o_wr_addr, 11'h205);
        drain(3);

        // Address wrap, then start colliding with valid mid-word while overflowed
        do_start(11'h7FF);
        feed(32, 16'h4000, 31, 1'b1);
        chk("wr_a1", o_wr_addr, 11'h000);
        drain(3);
        feed(84, 16'h5000, -1, 1'b0);
        chk("sc_ovf1", o_overflow, 1'b1);
        idle_in(1'b0);
        i_start = 1'b1; i_base_addr = 11'h300; i_valid = 1'b1; i_fp16_result = 16'hAAAA;
        tick();
        i_start = 1'b0;
        chk("sc_ovf0", o_overflow, 1'b0);
        chk("sc_flush", o_wr_valid, 1'b0);
        feed(2, 16'hBBB0, 1, 1'b0);
        chk("sc_addr", o_wr_addr, 11'h300);
        chk("sc_l0", o_wr_data[15:0], 16'hAAAA);
        chk("sc_strb", o_wr_strb, 32'h0000_003F);
        drain(3);

        // Reset mid-tile
        do_start(11'h050);
        feed(7, 16'h6000, -1, 1'b1);
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        chk("rs_idle", o_idle, 1'b1);
        chk("rs_data", o_wr_data, 256'd0);
        feed(16, 16'h7000, 15, 1'b1);
        chk("rs_addr", o_wr_addr, 11'h000);
        chk("rs_l0", o_wr_data[15:0], 16'h7000);
        drain(3);
        chk("rs_end_idle", o_idle, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
